// File: rtl/cubic_res_packer.sv
// Packs per-channel result vectors into wide output-buffer words, PACK vectors
// per word, and streams the words to the buffer through a 2-entry queue.
module cubic_res_packer #(
  parameter int SIZE     = 8,
  parameter int DATA_WID = 16,
  parameter int PACK     = 4,
  parameter int ADDR_WID = 10
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           new_tile,
  input  logic [ADDR_WID-1:0]            tile_base_addr,
  input  logic [5:0]                     out_height,
  input  logic [5:0]                     out_length,
  input  logic                           res_valid,
  input  logic [DATA_WID*SIZE-1:0]       res_pool,
  input  logic                           wr_ready,
  output logic                           wr_en,
  output logic [ADDR_WID-1:0]            wr_addr,
  output logic [PACK*DATA_WID*SIZE-1:0]  wr_data,
  output logic [PACK-1:0]                wr_mask,
  output logic                           busy,
  output logic                           tile_done,
  output logic                           overflow_err
);

  localparam int VEC_W  = DATA_WID * SIZE;
  localparam int WORD_W = PACK * VEC_W;
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PACK - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PACK, ST_DRAIN, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic [11:0]           total, vec_cnt, total_in;
  logic [SLOT_W-1:0]     slot_cnt;
  logic [ADDR_WID-1:0]   addr_q;
  logic [WORD_W-1:0]     pack_data, pack_nxt;
  logic [PACK-1:0]       pack_mask, mask_nxt;
  logic [WORD_W-1:0]     q_data [2];
  logic [PACK-1:0]       q_mask [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            q_cnt;
  logic                  start, accept, last_vec, push, pop, push_ok, drop;

  assign total_in = {6'd0, out_height} * {6'd0, out_length};
  assign start    = (state == ST_IDLE) && new_tile;
  assign accept   = (state == ST_PACK) && res_valid;
  assign last_vec = (vec_cnt + 12'd1) == total;
  assign push     = accept && ((slot_cnt == SLOT_LAST) || last_vec);
  assign pop      = (q_cnt != 2'd0) && wr_ready;
  // A full queue can still take a word when its head leaves on the same edge.
  assign push_ok  = push && ((q_cnt != 2'd2) || pop);
  assign drop     = push && !push_ok;

  assign wr_en     = (q_cnt != 2'd0);
  assign wr_addr   = addr_q;
  assign wr_data   = wr_en ? q_data[rd_ptr] : '0;
  assign wr_mask   = wr_en ? q_mask[rd_ptr] : '0;
  assign busy      = (state != ST_IDLE);
  assign tile_done = (state == ST_DONE);

  // Merge the incoming vector into the slot currently being filled.
  always_comb begin
    pack_nxt = pack_data;
    mask_nxt = pack_mask;
    for (int k = 0; k < PACK; k++) begin
      if (slot_cnt == SLOT_W'(k)) begin
        pack_nxt[k*VEC_W +: VEC_W] = res_pool;
        mask_nxt[k] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (new_tile) state_nxt = (total_in == 12'd0) ? ST_DONE : ST_PACK;
      ST_PACK:  if (push && last_vec) state_nxt = ST_DRAIN;
      ST_DRAIN: if (q_cnt == 2'd0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control: counters, address, queue pointers and the sticky error flag.
  always_ff @(posedge clock) begin
    if (rst) begin
      total        <= '0;
      vec_cnt      <= '0;
      slot_cnt     <= '0;
      pack_mask    <= '0;
      addr_q       <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      q_cnt        <= 2'd0;
      overflow_err <= 1'b0;
    end else begin
      if (start) begin
        total     <= total_in;
        vec_cnt   <= '0;
        slot_cnt  <= '0;
        pack_mask <= '0;
        addr_q    <= tile_base_addr;
      end else if (pop) begin
        addr_q    <= addr_q + 1'b1;
      end
      if (accept) begin
        vec_cnt   <= vec_cnt + 12'd1;
        slot_cnt  <= push ? '0 : slot_cnt + 1'b1;
        pack_mask <= push ? '0 : mask_nxt;
      end
      if (pop)     rd_ptr <= ~rd_ptr;
      if (push_ok) wr_ptr <= ~wr_ptr;
      q_cnt <= q_cnt + {1'b0, push_ok} - {1'b0, pop};
      if (drop || (res_valid && ((state == ST_IDLE) || (state == ST_DONE))))
        overflow_err <= 1'b1;
    end
  end

  // Datapath: word assembly and queue storage; validity is tracked by control.
  always_ff @(posedge clock) begin
    if (start)       pack_data <= '0;
    else if (accept) pack_data <= push ? '0 : pack_nxt;
    if (push_ok) begin
      q_data[wr_ptr] <= pack_nxt;
      q_mask[wr_ptr] <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_cubic_res_packer.sv
// Directed bench for cubic_res_packer: tiles of various shapes, stall, wrap, reset.
module tb_cubic_res_packer;

  localparam int SIZE = 8, DATA_WID = 16, PACK = 4, ADDR_WID = 10;
  localparam int VEC_W = SIZE * DATA_WID;
  localparam int WORD_W = PACK * VEC_W;

  logic                clock = 1'b0;
  logic                rst = 1'b1;
  logic                new_tile = 1'b0;
  logic [ADDR_WID-1:0] tile_base_addr = '0;
  logic [5:0]          out_height = '0, out_length = '0;
  logic                res_valid = 1'b0;
  logic [VEC_W-1:0]    res_pool = '0;
  logic                wr_ready = 1'b1;
  logic                wr_en;
  logic [ADDR_WID-1:0] wr_addr;
  logic [WORD_W-1:0]   wr_data;
  logic [PACK-1:0]     wr_mask;
  logic                busy, tile_done, overflow_err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [ADDR_WID-1:0] cap_addr [$];
  logic [WORD_W-1:0]   cap_data [$];
  logic [PACK-1:0]     cap_mask [$];

  cubic_res_packer #(.SIZE(SIZE), .DATA_WID(DATA_WID), .PACK(PACK), .ADDR_WID(ADDR_WID)) dut (
    .clock(clock), .rst(rst), .new_tile(new_tile), .tile_base_addr(tile_base_addr),
    .out_height(out_height), .out_length(out_length), .res_valid(res_valid),
    .res_pool(res_pool), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .busy(busy), .tile_done(tile_done),
    .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  // Record every accepted write and every cycle of tile_done.
  always @(posedge clock) begin
    if (wr_en && wr_ready) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_mask.push_back(wr_mask);
    end
    if (tile_done) done_cnt++;
  end

  function automatic logic [VEC_W-1:0] vec(int n);
    logic [VEC_W-1:0] v;
    logic [7:0] nb;
    nb = n[7:0];
    for (int c = 0; c < SIZE; c++) v[c*DATA_WID +: DATA_WID] = {nb, 8'(c)};
    return v;
  endfunction

  function automatic logic [WORD_W-1:0] word(int first, int cnt);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < cnt; k++) w[k*VEC_W +: VEC_W] = vec(first + k);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    cap_addr.delete();
    cap_data.delete();
    cap_mask.delete();
    done_cnt = 0;
  endtask

  task automatic start_tile(input logic [ADDR_WID-1:0] base, input logic [5:0] h, input logic [5:0] l);
    tile_base_addr = base;
    out_height = h;
    out_length = l;
    new_tile = 1'b1;
    step();
    new_tile = 1'b0;
  endtask

  task automatic send(input int first, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      res_valid = 1'b1;
      res_pool = vec(first + i);
      step();
    end
    res_valid = 1'b0;
    res_pool = '0;
  endtask

  task automatic run_until_idle(input string tag, input int max);
    for (int i = 0; i < max && busy; i++) step();
    chk({tag, "_idle_timeout"}, busy, 1'b0);
  endtask

  logic [WORD_W-1:0]   snap_data;
  logic [ADDR_WID-1:0] snap_addr;
  logic [PACK-1:0]     snap_mask;

  initial begin
    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, '0);
    chk("rst_wr_data", wr_data, '0);
    chk("rst_wr_mask", wr_mask, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tile_done", tile_done, 1'b0);
    chk("rst_overflow", overflow_err, 1'b0);

    // Full words, back-to-back, with first-word latency
    clear_log();
    start_tile(10'h010, 6'd2, 6'd4);
    chk("t1_busy", busy, 1'b1);
    send(0, 3);
    chk("t1_no_wr_early", wr_en, 1'b0);
    send(3, 1);
    chk("t1_latency_wr_en", wr_en, 1'b1);
    chk("t1_latency_addr", wr_addr, 10'h010);
    send(4, 4);
    run_until_idle("t1", 20);
    chk("t1_nwrites", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      chk("t1_addr0", cap_addr[0], 10'h010);
      chk("t1_addr1", cap_addr[1], 10'h011);
      chk("t1_mask0", cap_mask[0], 4'b1111);
      chk("t1_mask1", cap_mask[1], 4'b1111);
      chk("t1_data0", cap_data[0], word(0, 4));
      chk("t1_data1", cap_data[1], word(4, 4));
    end
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_overflow", overflow_err, 1'b0);

    // Partial last word
    clear_log();
    start_tile(10'h020, 6'd1, 6'd5);
    send(16, 5);
    run_until_idle("t2", 20);
    chk("t2_nwrites", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      chk("t2_addr1", cap_addr[1], 10'h021);
      chk("t2_mask0", cap_mask[0], 4'b1111);
      chk("t2_mask1", cap_mask[1], 4'b0001);
      chk("t2_data1", cap_data[1], word(20, 1));
    end
    chk("t2_done_pulses", done_cnt, 1);

    // Zero-size tile
    clear_log();
    start_tile(10'h030, 6'd0, 6'd7);
    chk("t3_done_high", tile_done, 1'b1);
    chk("t3_busy", busy, 1'b1);
    step();
    chk("t3_done_low", tile_done, 1'b0);
    chk("t3_idle", busy, 1'b0);
    chk("t3_nwrites", cap_addr.size(), 0);
    chk("t3_done_pulses", done_cnt, 1);

    // Address wrap
    clear_log();
    start_tile(10'h3FF, 6'd2, 6'd4);
    send(32, 8);
    run_until_idle("t4", 20);
    chk("t4_nwrites", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      chk("t4_addr0", cap_addr[0], 10'h3FF);
      chk("t4_addr1", cap_addr[1], 10'h000);
      chk("t4_data1", cap_data[1], word(36, 4));
    end

    // Reset mid-tile, then a clean tile
    clear_log();
    start_tile(10'h050, 6'd2, 6'd4);
    send(48, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_wr_en", wr_en, 1'b0);
    chk("t5_rst_addr", wr_addr, '0);
    start_tile(10'h060, 6'd1, 6'd4);
    send(128, 4);
    run_until_idle("t5", 20);
    chk("t5_nwrites", cap_addr.size(), 1);
    if (cap_addr.size() == 1) begin
      chk("t5_addr", cap_addr[0], 10'h060);
      chk("t5_mask", cap_mask[0], 4'b1111);
      chk("t5_data", cap_data[0], word(128, 4));
    end

    // res_valid while idle flags an error; reset clears it
    res_valid = 1'b1;
    res_pool = vec(7);
    step();
    res_valid = 1'b0;
    chk("t6_idle_valid_err", overflow_err, 1'b1);
    chk("t6_idle_no_wr", wr_en, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_err_cleared", overflow_err, 1'b0);

    // Backpressure: 20 stalled cycles across a 16-vector tile
    clear_log();
    wr_ready = 1'b0;
    start_tile(10'h100, 6'd4, 6'd4);
    send(64, 8);
    chk("t7_stall_wr_en", wr_en, 1'b1);
    chk("t7_no_err_yet", overflow_err, 1'b0);
    snap_data = wr_data;
    snap_addr = wr_addr;
    snap_mask = wr_mask;
    chk("t7_head_data", snap_data, word(64, 4));
    send(72, 8);
    step(); step(); step();
    chk("t7_overflow", overflow_err, 1'b1);
    chk("t7_stable_data", wr_data, snap_data);
    chk("t7_stable_addr", wr_addr, snap_addr);
    chk("t7_stable_mask", wr_mask, snap_mask);
    chk("t7_no_writes", cap_addr.size(), 0);
    wr_ready = 1'b1;
    run_until_idle("t7", 20);
    chk("t7_nwrites", cap_addr.size(), 2);
    if (cap_addr.size() == 2) begin
      chk("t7_addr0", cap_addr[0], 10'h100);
      chk("t7_addr1", cap_addr[1], 10'h101);
      chk("t7_data1", cap_data[1], word(68, 4));
    end
    chk("t7_done_pulses", done_cnt, 1);
    chk("t7_err_sticky", overflow_err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
